// File: rtl/retire_mc.sv
// Multi-lane retire stage: tag-based wrong-path kill, 2-stage register
// write-back pipe, PC redirect, and a store queue drained over valid/ready.
module retire_mc #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUNITS    = 4,
  parameter int unsigned ADDR_LANE = 1,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [NUNITS*XLEN-1:0]      result,
  input  logic [$clog2(NUNITS)-1:0]   unit_sel,
  input  logic [TAG_W-1:0]            instruction_tag,
  input  logic                        jump,
  input  logic                        we,
  input  logic [4:0]                  rd,
  input  logic                        write_in,
  input  logic [1:0]                  size_in,
  input  logic                        mem_ready,
  output logic                        reg_we,
  output logic [4:0]                  reg_addr,
  output logic [XLEN-1:0]             WrData,
  output logic                        new_pc_valid,
  output logic [XLEN-1:0]             New_pc,
  output logic [TAG_W-1:0]            curr_tag,
  output logic                        mem_valid,
  output logic [XLEN-1:0]             write_address,
  output logic [XLEN-1:0]             DATA_out,
  output logic [1:0]                  size,
  output logic                        sb_full,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_overflow,
  output logic [15:0]                 kill_count
);

  localparam int unsigned SEL_W = $clog2(NUNITS);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  sel_data;
  logic [XLEN-1:0]  addr_data;
  logic             accept_c;
  logic             kill_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] rd_nxt;
  logic [XLEN-1:0]  head_addr_nxt;
  logic [XLEN-1:0]  head_data_nxt;
  logic [1:0]       head_size_nxt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [XLEN-1:0]  sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]  sb_data_q [SB_DEPTH];
  logic [1:0]       sb_size_q [SB_DEPTH];

  logic             wb1_v;
  logic [4:0]       wb1_addr;
  logic [XLEN-1:0]  wb1_data;

  // Lane selection and kill/accept decision against the current tag
  always_comb begin
    sel_data = '0;
    for (int u = 0; u < NUNITS; u++) begin
      if (unit_sel == SEL_W'(u)) sel_data = result[u*XLEN +: XLEN];
    end
    addr_data = result[ADDR_LANE*XLEN +: XLEN];
    accept_c  = valid_in && (instruction_tag == curr_tag);
    kill_c    = valid_in && (instruction_tag != curr_tag);
  end

  // Store-queue push/pop arbitration and next head (bypass when the pushed
  // entry becomes the head in the same cycle)
  always_comb begin
    pop_c  = mem_valid && mem_ready;
    push_c = accept_c && write_in && ((sb_count != CNT_W'(SB_DEPTH)) || pop_c);
    drop_c = accept_c && write_in && !push_c;
    count_nxt = sb_count;
    if (push_c && !pop_c) count_nxt = sb_count + CNT_W'(1);
    if (!push_c && pop_c) count_nxt = sb_count - CNT_W'(1);
    rd_nxt = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    if (push_c && (wr_ptr == rd_nxt)) begin
      head_addr_nxt = addr_data;
      head_data_nxt = sel_data;
      head_size_nxt = size_in;
    end else begin
      head_addr_nxt = sb_addr_q[rd_nxt];
      head_data_nxt = sb_data_q[rd_nxt];
      head_size_nxt = sb_size_q[rd_nxt];
    end
  end

  // Store-queue storage; validity is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (push_c) begin
      sb_addr_q[wr_ptr] <= addr_data;
      sb_data_q[wr_ptr] <= sel_data;
      sb_size_q[wr_ptr] <= size_in;
    end
  end

  // Store-queue pointers, occupancy and registered head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sb_count      <= '0;
      sb_full       <= 1'b0;
      sb_overflow   <= 1'b0;
      mem_valid     <= 1'b0;
      write_address <= '0;
      DATA_out      <= '0;
      size          <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_nxt;
      sb_count    <= count_nxt;
      sb_full     <= (count_nxt == CNT_W'(SB_DEPTH));
      sb_overflow <= sb_overflow || drop_c;
      mem_valid   <= (count_nxt != '0);
      if (count_nxt != '0) begin
        write_address <= head_addr_nxt;
        DATA_out      <= head_data_nxt;
        size          <= head_size_nxt;
      end
    end
  end

  // Write-back pipe, redirect, retire tag and kill counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb1_v        <= 1'b0;
      wb1_addr     <= '0;
      wb1_data     <= '0;
      reg_we       <= 1'b0;
      reg_addr     <= '0;
      WrData       <= '0;
      new_pc_valid <= 1'b0;
      New_pc       <= '0;
      curr_tag     <= '0;
      kill_count   <= '0;
    end else begin
      wb1_v        <= accept_c && we;
      wb1_addr     <= rd;
      wb1_data     <= sel_data;
      reg_we       <= wb1_v;
      reg_addr     <= wb1_addr;
      WrData       <= wb1_data;
      new_pc_valid <= accept_c && jump;
      if (accept_c && jump) begin
        New_pc   <= addr_data;
        curr_tag <= curr_tag + TAG_W'(1);
      end
      if (kill_c && (kill_count != 16'hFFFF)) kill_count <= kill_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_retire_mc.sv
// Directed self-checking bench for retire_mc.
module tb_retire_mc;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [4*XLEN-1:0] result;
  logic [1:0]        unit_sel;
  logic [3:0]        instruction_tag;
  logic              jump;
  logic              we;
  logic [4:0]        rd;
  logic              write_in;
  logic [1:0]        size_in;
  logic              mem_ready;
  logic              reg_we;
  logic [4:0]        reg_addr;
  logic [XLEN-1:0]   WrData;
  logic              new_pc_valid;
  logic [XLEN-1:0]   New_pc;
  logic [3:0]        curr_tag;
  logic              mem_valid;
  logic [XLEN-1:0]   write_address;
  logic [XLEN-1:0]   DATA_out;
  logic [1:0]        size;
  logic              sb_full;
  logic [2:0]        sb_count;
  logic              sb_overflow;
  logic [15:0]       kill_count;

  int checks = 0;
  int failures = 0;

  retire_mc dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .result(result),
    .unit_sel(unit_sel), .instruction_tag(instruction_tag), .jump(jump),
    .we(we), .rd(rd), .write_in(write_in), .size_in(size_in),
    .mem_ready(mem_ready), .reg_we(reg_we), .reg_addr(reg_addr),
    .WrData(WrData), .new_pc_valid(new_pc_valid), .New_pc(New_pc),
    .curr_tag(curr_tag), .mem_valid(mem_valid), .write_address(write_address),
    .DATA_out(DATA_out), .size(size), .sb_full(sb_full), .sb_count(sb_count),
    .sb_overflow(sb_overflow), .kill_count(kill_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; jump = 1'b0; we = 1'b0; write_in = 1'b0;
    instruction_tag = '0; rd = '0; unit_sel = '0; size_in = '0;
  endtask

  task automatic present(input logic [3:0] t, input logic j, input logic w,
                         input logic [4:0] r, input logic [1:0] s,
                         input logic st, input logic [1:0] sz);
    valid_in = 1'b1; instruction_tag = t; jump = j; we = w; rd = r;
    unit_sel = s; write_in = st; size_in = sz;
  endtask

  task automatic set_lane(input int u, input logic [XLEN-1:0] v);
    result[u*XLEN +: XLEN] = v;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle(); mem_ready = 1'b0; result = '0;
    reset = 1'b0;
    step();
    step();
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL reset_reg_we got %b exp 0", reg_we); end
    checks++; if (reg_addr !== 5'd0 || WrData !== 32'd0) begin failures++; $display("FAIL reset_wb got %h/%h exp 0/0", reg_addr, WrData); end
    checks++; if (new_pc_valid !== 1'b0 || New_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got %b/%h exp 0/0", new_pc_valid, New_pc); end
    checks++; if (curr_tag !== 4'd0) begin failures++; $display("FAIL reset_tag got %h exp 0", curr_tag); end
    checks++; if (mem_valid !== 1'b0 || write_address !== 32'd0 || DATA_out !== 32'd0 || size !== 2'd0) begin failures++; $display("FAIL reset_head got %b %h %h %h exp all 0", mem_valid, write_address, DATA_out, size); end
    checks++; if (sb_full !== 1'b0 || sb_count !== 3'd0 || sb_overflow !== 1'b0) begin failures++; $display("FAIL reset_sb got %b %h %b exp 0 0 0", sb_full, sb_count, sb_overflow); end
    checks++; if (kill_count !== 16'd0) begin failures++; $display("FAIL reset_kill got %h exp 0", kill_count); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_writeback();
    set_lane(2, 32'hDEADBEEF);
    present(4'd0, 1'b0, 1'b1, 5'd5, 2'd2, 1'b0, 2'd0);
    step();
    idle();
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL wb_early got %b exp 0", reg_we); end
    step();
    checks++; if (reg_we !== 1'b1 || reg_addr !== 5'd5 || WrData !== 32'hDEADBEEF) begin failures++; $display("FAIL wb_data got %b %h %h exp 1 05 deadbeef", reg_we, reg_addr, WrData); end
    step();
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL wb_end got %b exp 0", reg_we); end
  endtask

  task automatic test_jump_kill();
    set_lane(1, 32'h80);
    present(4'd0, 1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0);
    step();
    idle();
    checks++; if (new_pc_valid !== 1'b1 || New_pc !== 32'h80 || curr_tag !== 4'd1) begin failures++; $display("FAIL jump got %b %h %h exp 1 80 1", new_pc_valid, New_pc, curr_tag); end
    present(4'd0, 1'b0, 1'b1, 5'd7, 2'd0, 1'b0, 2'd0);
    step();
    idle();
    checks++; if (new_pc_valid !== 1'b0 || kill_count !== 16'd1) begin failures++; $display("FAIL kill got %b %h exp 0 1", new_pc_valid, kill_count); end
    step();
    checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL kill_wb1 got %b exp 0", reg_we); end
    step();
    checks++; if (reg_we !== 1'b0 || New_pc !== 32'h80 || curr_tag !== 4'd1) begin failures++; $display("FAIL kill_wb2 got %b %h %h exp 0 80 1", reg_we, New_pc, curr_tag); end
  endtask

  task automatic test_tag_wrap();
    for (int i = 1; i <= 15; i++) begin
      set_lane(1, 32'h100 + 32'(i));
      present(4'(i), 1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0);
      step();
      if (i == 14) begin
        checks++; if (curr_tag !== 4'd15) begin failures++; $display("FAIL tag_15 got %h exp f", curr_tag); end
      end
    end
    idle();
    checks++; if (curr_tag !== 4'd0 || New_pc !== 32'h10F || new_pc_valid !== 1'b1) begin failures++; $display("FAIL tag_wrap got %h %h %b exp 0 10f 1", curr_tag, New_pc, new_pc_valid); end
    set_lane(0, 32'h1234);
    present(4'd0, 1'b0, 1'b1, 5'd0, 2'd0, 1'b0, 2'd0);
    step();
    idle();
    step();
    checks++; if (reg_we !== 1'b1 || reg_addr !== 5'd0 || WrData !== 32'h1234 || kill_count !== 16'd1) begin failures++; $display("FAIL wrap_accept got %b %h %h %h exp 1 00 1234 1", reg_we, reg_addr, WrData, kill_count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lane(1, 32'hA000 + 32'(i));
      set_lane(3, 32'hD000 + 32'(i));
      present(4'd0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b1, 2'(i % 3));
      step();
      if (i == 3) begin
        checks++; if (sb_full !== 1'b1 || sb_count !== 3'd4 || sb_overflow !== 1'b0) begin failures++; $display("FAIL sb_fill got %b %h %b exp 1 4 0", sb_full, sb_count, sb_overflow); end
      end
    end
    idle();
    checks++; if (sb_count !== 3'd4 || sb_overflow !== 1'b1 || sb_full !== 1'b1) begin failures++; $display("FAIL sb_drop got %h %b %b exp 4 1 1", sb_count, sb_overflow, sb_full); end
    checks++; if (mem_valid !== 1'b1 || write_address !== 32'hA000 || DATA_out !== 32'hD000 || size !== 2'd0) begin failures++; $display("FAIL sb_hold got %b %h %h %h exp 1 a000 d000 0", mem_valid, write_address, DATA_out, size); end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_valid !== 1'b1 || write_address !== 32'hA000 + 32'(i) || DATA_out !== 32'hD000 + 32'(i) || size !== 2'(i % 3)) begin failures++; $display("FAIL drain_%0d got %b %h %h %h exp 1 %h %h %h", i, mem_valid, write_address, DATA_out, size, 32'hA000 + 32'(i), 32'hD000 + 32'(i), 2'(i % 3)); end
      step();
    end
    checks++; if (mem_valid !== 1'b0 || sb_count !== 3'd0 || sb_full !== 1'b0) begin failures++; $display("FAIL drain_empty got %b %h %b exp 0 0 0", mem_valid, sb_count, sb_full); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_lane(1, 32'hB000 + 32'(i));
      set_lane(3, 32'hE000 + 32'(i));
      present(4'd0, 1'b0, 1'b0, 5'd0, 2'd3, 1'b1, 2'd2);
      if (i == 4) mem_ready = 1'b1;
      step();
    end
    idle();
    mem_ready = 1'b0;
    checks++; if (sb_count !== 3'd4 || sb_full !== 1'b1 || sb_overflow !== 1'b0) begin failures++; $display("FAIL pushpop_count got %h %b %b exp 4 1 0", sb_count, sb_full, sb_overflow); end
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (mem_valid !== 1'b1 || write_address !== 32'hB000 + 32'(i) || DATA_out !== 32'hE000 + 32'(i) || size !== 2'd2) begin failures++; $display("FAIL pushpop_drain_%0d got %b %h %h %h exp 1 %h %h 2", i, mem_valid, write_address, DATA_out, size, 32'hB000 + 32'(i), 32'hE000 + 32'(i)); end
      step();
    end
    checks++; if (mem_valid !== 1'b0 || sb_count !== 3'd0) begin failures++; $display("FAIL pushpop_empty got %b %h exp 0 0", mem_valid, sb_count); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_lane(1, 32'hC000);
    set_lane(2, 32'h5555);
    present(4'd0, 1'b1, 1'b1, 5'd9, 2'd2, 1'b1, 2'd2);
    step();
    checks++; if (new_pc_valid !== 1'b1 || curr_tag !== 4'd1 || sb_count !== 3'd1 || mem_valid !== 1'b1 || write_address !== 32'hC000) begin failures++; $display("FAIL jump_store got %b %h %h %b %h exp 1 1 1 1 c000", new_pc_valid, curr_tag, sb_count, mem_valid, write_address); end
    set_lane(1, 32'hC004);
    present(4'd1, 1'b0, 1'b1, 5'd10, 2'd2, 1'b1, 2'd2);
    step();
    idle();
    mem_ready = 1'b1;
    checks++; if (sb_count !== 3'd2 || reg_we !== 1'b1 || reg_addr !== 5'd9) begin failures++; $display("FAIL mid_pre1 got %h %b %h exp 2 1 09", sb_count, reg_we, reg_addr); end
    step();
    checks++; if (sb_count !== 3'd1 || reg_we !== 1'b1 || reg_addr !== 5'd10 || write_address !== 32'hC004) begin failures++; $display("FAIL mid_pre2 got %h %b %h %h exp 1 1 0a c004", sb_count, reg_we, reg_addr, write_address); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || sb_count !== 3'd0 || reg_we !== 1'b0 || curr_tag !== 4'd0) begin failures++; $display("FAIL async_reset got %b %h %b %h exp 0 0 0 0", mem_valid, sb_count, reg_we, curr_tag); end
    mem_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    checks++; if (mem_valid !== 1'b0 || reg_we !== 1'b0 || sb_count !== 3'd0) begin failures++; $display("FAIL post_reset got %b %b %h exp 0 0 0", mem_valid, reg_we, sb_count); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_jump_kill();
    test_tag_wrap();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
